// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and a one-entry skid buffer.
// in_ready is a flop, so downstream stalls never reach upstream combinationally.
module pipe_stage_skid #(
    parameter int unsigned        DATA_W      = 32,
    parameter logic [DATA_W-1:0]  RESET_DATA  = '0,
    parameter logic [DATA_W-1:0]  BUBBLE_DATA = '0,
    parameter int unsigned        CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic                in_ready_q, out_valid_q;
    logic [1:0]          occ_q, occ_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                accept, pop;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    // Next-state and datapath; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        occ_d   = occ_q;
        stall_d = stall_q;

        if (out_valid_q && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE_DATA;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (pop) begin
                        main_d  = BUBBLE_DATA;
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE_DATA;
                end
            endcase
        end

        case (state_d)
            ONE:     occ_d = 2'd1;
            TWO:     occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    // Status outputs are flopped from the next state so they never lag the storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_q      <= RESET_DATA;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
            occ_q       <= occ_d;
            stall_q     <= stall_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_data     = main_q;
    assign occupancy    = occ_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid: reset, streaming, backpressure,
// flush, counter saturation and asynchronous mid-cycle reset.
module tb_pipe_stage_skid;

    localparam int unsigned       DATA_W = 32;
    localparam int unsigned       CNT_W  = 4;
    localparam logic [DATA_W-1:0] RST_D  = 32'hDEAD_0000;
    localparam logic [DATA_W-1:0] BUB_D  = 32'h0000_F00D;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cycles;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(
        .DATA_W      (DATA_W),
        .RESET_DATA  (RST_D),
        .BUBBLE_DATA (BUB_D),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check({tag, ".out_data"},  out_data,       RST_D);
        check({tag, ".occ"},       32'(occupancy), 32'd0);
        check({tag, ".stall"},     32'(stall_cycles), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset values
        step();
        check_reset_vals("rst");
        reset = 1'b0;

        // Streaming: one item per cycle, 1-cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data = 32'(i);
            step();
            check("stream.valid", 32'(out_valid), 32'd1);
            check("stream.data",  out_data,       32'(i));
            check("stream.occ",   32'(occupancy), 32'd1);
            check("stream.rdy",   32'(in_ready),  32'd1);
        end
        in_valid = 1'b0;
        step();
        check("drain.valid", 32'(out_valid), 32'd0);
        check("drain.data",  out_data,       BUB_D);
        check("drain.stall", 32'(stall_cycles), 32'd0);

        // Backpressure: fill both entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_000A;
        step();
        check("bp.a.data",  out_data,          32'h0000_000A);
        check("bp.a.occ",   32'(occupancy),    32'd1);
        check("bp.a.stall", 32'(stall_cycles), 32'd0);
        in_data = 32'h0000_000B;
        step();
        check("bp.b.occ",   32'(occupancy),    32'd2);
        check("bp.b.rdy",   32'(in_ready),     32'd0);
        check("bp.b.data",  out_data,          32'h0000_000A);
        check("bp.b.stall", 32'(stall_cycles), 32'd1);
        in_data = 32'h0000_00EE;   // ignored while in_ready=0
        step();
        check("bp.hold.data",  out_data,          32'h0000_000A);
        check("bp.hold.stall", 32'(stall_cycles), 32'd2);
        check("bp.hold.occ",   32'(occupancy),    32'd2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp.popA.data",  out_data,          32'h0000_000B);
        check("bp.popA.occ",   32'(occupancy),    32'd1);
        check("bp.popA.rdy",   32'(in_ready),     32'd1);
        check("bp.popA.stall", 32'(stall_cycles), 32'd2);
        step();
        check("bp.popB.valid", 32'(out_valid), 32'd0);
        check("bp.popB.data",  out_data,       BUB_D);

        // Flush while holding two entries, with a new item offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_00D1;
        step();
        in_data = 32'h0000_00E2;
        step();
        check("fl.pre.occ", 32'(occupancy), 32'd2);
        flush   = 1'b1;
        in_data = 32'h0000_00C3;
        step();
        check("fl.occ",   32'(occupancy), 32'd0);
        check("fl.valid", 32'(out_valid), 32'd0);
        check("fl.data",  out_data,       BUB_D);
        check("fl.rdy",   32'(in_ready),  32'd1);
        check("fl.stall", 32'(stall_cycles), 32'd4);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("fl.noC.valid", 32'(out_valid), 32'd0);
            check("fl.noC.data",  out_data,       BUB_D);
        end

        // Saturating stall counter (re-reset for a clean start)
        reset = 1'b1;
        #2;
        reset     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0055;
        step();
        check("sat.start", 32'(stall_cycles), 32'd0);
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("sat.cnt",  32'(stall_cycles), (k > 15) ? 32'd15 : 32'(k));
            check("sat.data", out_data,          32'h0000_0055);
        end

        // Asynchronous reset mid-cycle with both entries full
        in_valid = 1'b1;
        in_data  = 32'h0000_0066;
        step();
        check("ar.pre.occ", 32'(occupancy), 32'd2);
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check_reset_vals("ar");
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_0077;
        step();
        check("ar.resume.valid", 32'(out_valid), 32'd1);
        check("ar.resume.data",  out_data,       32'h0000_0077);
        in_valid = 1'b0;
        step();
        check("ar.resume.empty", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
